intr_ctrl: RTL and testbench
============================

# intr_ctrl

Two-line interrupt controller that sits between the external interrupt pins `intr1`/`intr2` and the single-cycle CPU core. It edge-detects and latches requests, applies a software-writable mask, and arbitrates with fixed priority (`intr1` over `intr2`). It presents one request at a time to the CPU together with a handler vector, then tracks the in-service interrupt until the CPU signals return-from-interrupt. There is no nesting: a new request is issued only after the current one is retired.

## Interface
Parameters:
- `VEC_W`, 10: width of the handler vector, matching the CPU PC width.
- `VEC1`, 10'h3F0: handler address for `intr1`.
- `VEC2`, 10'h3F8: handler address for `intr2`.
- `MASK_RST`, 2'b11: reset value of the mask register. Bit0 = `intr1`, bit1 = `intr2`; 1 = enabled.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `intr1`, `intr2` in 1 each: interrupt lines, rising-edge triggered.
- `mask_we` in 1: when high, load `mask_in` into the mask register.
- `mask_in` in 2: new mask value.
- `ack` in 1: CPU accepts the current request (PC saved, jumping to `vector`).
- `iret` in 1: CPU executed return-from-interrupt.
- `irq` out 1: request to the CPU.
- `vector` out VEC_W: handler address; valid while `irq`=1.
- `pending` out 2: latched, not-yet-accepted requests (bit0 = `intr1`).
- `in_service` out 2: one-hot; the interrupt currently being handled.

## Operation
- **Reset** (`reset`=0, asynchronous):
  - Outputs: `irq`=0, `vector`=0, `pending`=0, `in_service`=0.
  - Internal: mask=`MASK_RST`, edge-detect history=0, state=IDLE.
- **Edge detect:** `rise[i] = intr_i & ~intr_i_q`, where `intr_i_q` is the previous sample. A detected rise sets `pending[i]`. A level held high does not retrigger.
- **Pending set/clear:** a bit is cleared only when its request is acked. If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- **Mask:** `mask_we` writes take effect on the next edge. Masked lines still latch into `pending`; they are ignored only by arbitration.
- **State machine:**
  - **IDLE:** `eligible = pending & mask`. If nonzero, pick winner bit0 before bit1, register `irq`=1 and `vector`=VEC1 or VEC2, record the winner, go to REQ.
  - **REQ:** hold `irq` and `vector` stable until `ack`. On `ack`, clear the winner's pending bit, set its `in_service` bit, drop `irq`, drop `vector` to 0, go to SERVICE. A mask change during REQ does not withdraw the request.
  - **SERVICE:** on `iret`, clear `in_service` and return to IDLE. New edges keep latching into `pending` in this state.
- **Ignored inputs:** `ack` outside REQ and `iret` outside SERVICE have no effect.
- **Consecutive requests:** the earliest next `irq` is the cycle after `iret`, because it is issued from IDLE.

## Timing
- **Request latency:** an edge sampled at clock edge N sets `pending` after N. `irq` is high after edge N+1, giving 2 cycles from the sampled rise to `irq`.
- **Ack response:** `ack` sampled at edge M gives `irq`=0 and `in_service` set after M.
- **Iret response:** `iret` sampled at edge K gives `in_service`=0 after K. Any eligible pending request raises `irq` after K+1.
- **Registered outputs:** all outputs come straight from flops, with no combinational path from inputs.
- **Reset mid-operation:** reset asserted in any state clears everything immediately. Requests in flight are lost. The first post-reset edge sees `intr_q`=0, so a line already high at reset release counts as a rising edge.

## Configuration
- **`INTC_SYNC_EN` defined:**
  - `intr1`/`intr2` pass through a 2-flop synchronizer before edge detection.
  - Request latency becomes 4 cycles.
  - Synchronizer flops reset to 0.
- **`INTC_SYNC_EN` undefined:**
  - Lines feed edge detection directly and latency is 2 cycles.
  - Inputs are assumed synchronous to `clk`.

## Test plan
1. **Reset values:** release `reset` with both lines low.
   - Expect all outputs 0.
   - Then pulse `intr1` high 1 cycle: `irq`=1, `vector`=10'h3F0 exactly 2 cycles after the sampled rise (4 with `INTC_SYNC_EN`).
2. **Simultaneous rise and priority:** raise `intr1` and `intr2` in the same cycle.
   - `vector`=3F0 and `pending`=2'b11 while `irq` is high.
   - `ack` gives `in_service`=01 and `pending`=10.
   - `iret` gives `irq`=1, `vector`=3F8 one cycle later.
3. **Mask:** write `mask_in`=2'b01, then pulse `intr2`.
   - `pending`=10 and `irq` stays 0 for 10 cycles.
   - Write mask=11: `irq`=1, `vector`=3F8 one cycle after the write lands.
4. **Stretched ack:** hold off `ack` for 5 cycles in REQ.
   - `irq` and `vector` stay stable throughout.
   - Stray `ack`/`iret` pulses in IDLE cause no change.
5. **Edge during service:** pulse `intr1` while in SERVICE for `intr1`.
   - `pending`=01 and `irq`=0 until `iret`.
   - Re-request follows one cycle after `iret`.
   - Holding `intr1` high produces no second edge.
6. **Reset in REQ:** assert `reset` low asynchronously between clock edges while in REQ.
   - `irq`, `pending` and `in_service` go to 0 immediately.
   - The mask returns to 11.

Source files
------------

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - two-line edge-triggered interrupt controller, fixed priority, no nesting
// Optional input synchronizer: define INTC_SYNC_EN
module intr_ctrl #(
    parameter int               VEC_W    = 10,
    parameter logic [VEC_W-1:0] VEC1     = VEC_W'(10'h3F0),
    parameter logic [VEC_W-1:0] VEC2     = VEC_W'(10'h3F8),
    parameter logic [1:0]       MASK_RST = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             intr1,
    input  logic             intr2,
    input  logic             mask_we,
    input  logic [1:0]       mask_in,
    input  logic             ack,
    input  logic             iret,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    output logic [1:0]       pending,
    output logic [1:0]       in_service
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_line_q;
    logic [1:0]       r_mask;
    logic [1:0]       r_pending;
    logic [1:0]       r_winner;
    logic [1:0]       r_in_service;
    logic             r_irq;
    logic [VEC_W-1:0] r_vector;

    logic [1:0]       w_line;
    logic [1:0]       w_rise;
    logic [1:0]       w_eligible;
    logic [1:0]       w_win;
    logic [1:0]       w_clr;

`ifdef INTC_SYNC_EN
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {intr2, intr1};
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;
`else
    assign w_line = {intr2, intr1};
`endif

    assign w_rise     = w_line & ~r_line_q;
    assign w_eligible = r_pending & r_mask;
    assign w_win      = w_eligible[0] ? 2'b01 : (w_eligible[1] ? 2'b10 : 2'b00);
    // Only an accepted request retires its pending bit; a same-cycle rise re-sets it.
    assign w_clr      = (r_state == ST_REQ && ack) ? r_winner : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_q <= 2'b00;
            r_mask   <= MASK_RST;
            r_pending <= 2'b00;
        end else begin
            r_line_q  <= w_line;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_winner     <= 2'b00;
            r_in_service <= 2'b00;
            r_irq        <= 1'b0;
            r_vector     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win != 2'b00) begin
                        r_irq    <= 1'b1;
                        r_vector <= w_win[0] ? VEC1 : VEC2;
                        r_winner <= w_win;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_irq        <= 1'b0;
                        r_vector     <= '0;
                        r_in_service <= r_winner;
                        r_state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (iret) begin
                        r_in_service <= 2'b00;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq        = r_irq;
    assign vector     = r_vector;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

`ifdef INTC_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       intr1 = 1'b0;
    logic       intr2 = 1'b0;
    logic       mask_we = 1'b0;
    logic [1:0] mask_in = 2'b00;
    logic       ack = 1'b0;
    logic       iret = 1'b0;
    logic       irq;
    logic [9:0] vector;
    logic [1:0] pending;
    logic [1:0] in_service;

    logic [14:0] obs;
    logic [14:0] exp_v;
    int          n_checks = 0;
    int          n_pass = 0;

    intr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .intr1      (intr1),
        .intr2      (intr2),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .ack        (ack),
        .iret       (iret),
        .irq        (irq),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    assign obs = {irq, vector, pending, in_service};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        exp_v = {1'b0, 10'h000, 2'b00, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_held obs=%h exp=%h", obs, exp_v); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_released obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b1;
        step();
        intr1 = 1'b0;
        repeat (EXTRA) step();
        exp_v = {1'b0, 10'h000, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL latency_pending obs=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        exp_v = {1'b1, 10'h3F0, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL latency_irq obs=%h exp=%h", obs, exp_v); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b00, 2'b01};
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_ack obs=%h exp=%h", obs, exp_v); else n_pass++;
        iret = 1'b1;
        step();
        iret = 1'b0;
        step();
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_iret obs=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_priority();
        intr1 = 1'b1;
        intr2 = 1'b1;
        step();
        intr1 = 1'b0;
        intr2 = 1'b0;
        repeat (EXTRA) step();
        step();
        exp_v = {1'b1, 10'h3F0, 2'b11, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_first obs=%h exp=%h", obs, exp_v); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b10, 2'b01};
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_ack1 obs=%h exp=%h", obs, exp_v); else n_pass++;
        iret = 1'b1;
        step();
        iret = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b10, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_iret1 obs=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        exp_v = {1'b1, 10'h3F8, 2'b10, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_second obs=%h exp=%h", obs, exp_v); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b00, 2'b10};
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_ack2 obs=%h exp=%h", obs, exp_v); else n_pass++;
        iret = 1'b1;
        step();
        iret = 1'b0;
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL prio_iret2 obs=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_in = 2'b01;
        step();
        mask_we = 1'b0;
        intr2 = 1'b1;
        step();
        intr2 = 1'b0;
        repeat (EXTRA) step();
        exp_v = {1'b0, 10'h000, 2'b10, 2'b00};
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) $display("FAIL mask_hold cyc=%0d obs=%h exp=%h", i, obs, exp_v); else n_pass++;
        end
        mask_we = 1'b1;
        mask_in = 2'b11;
        step();
        mask_we = 1'b0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL mask_write obs=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        exp_v = {1'b1, 10'h3F8, 2'b10, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL mask_unmasked obs=%h exp=%h", obs, exp_v); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        iret = 1'b1;
        step();
        iret = 1'b0;
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL mask_retire obs=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_stretched_ack();
        ack = 1'b1;
        iret = 1'b1;
        repeat (2) step();
        ack = 1'b0;
        iret = 1'b0;
        step();
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL stray_idle obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b1;
        step();
        intr1 = 1'b0;
        repeat (EXTRA) step();
        step();
        exp_v = {1'b1, 10'h3F0, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            iret = (i == 1);
            mask_we = (i == 2);
            mask_in = (i == 2) ? 2'b00 : 2'b11;
            step();
            n_checks++;
            if (obs !== exp_v) $display("FAIL stretch_hold cyc=%0d obs=%h exp=%h", i, obs, exp_v); else n_pass++;
        end
        iret = 1'b0;
        mask_we = 1'b1;
        mask_in = 2'b11;
        ack = 1'b1;
        step();
        ack = 1'b0;
        mask_we = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b00, 2'b01};
        n_checks++;
        if (obs !== exp_v) $display("FAIL stretch_ack obs=%h exp=%h", obs, exp_v); else n_pass++;
        iret = 1'b1;
        step();
        iret = 1'b0;
        step();
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL stretch_iret obs=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_edge_in_service();
        intr1 = 1'b1;
        step();
        intr1 = 1'b0;
        repeat (EXTRA) step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b00, 2'b01};
        n_checks++;
        if (obs !== exp_v) $display("FAIL svc_enter obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b1;
        step();
        repeat (EXTRA) step();
        exp_v = {1'b0, 10'h000, 2'b01, 2'b01};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp_v) $display("FAIL svc_latched cyc=%0d obs=%h exp=%h", i, obs, exp_v); else n_pass++;
            step();
        end
        iret = 1'b1;
        step();
        iret = 1'b0;
        exp_v = {1'b0, 10'h000, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL svc_iret obs=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        exp_v = {1'b1, 10'h3F0, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL svc_rerequest obs=%h exp=%h", obs, exp_v); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        iret = 1'b1;
        step();
        iret = 1'b0;
        repeat (3) step();
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL svc_level_no_retrigger obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b0;
        repeat (EXTRA + 1) step();
    endtask

    task automatic test_reset_in_req();
        mask_we = 1'b1;
        mask_in = 2'b10;
        step();
        mask_we = 1'b0;
        intr2 = 1'b1;
        step();
        intr2 = 1'b0;
        repeat (EXTRA) step();
        step();
        exp_v = {1'b1, 10'h3F8, 2'b10, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL rst_req_setup obs=%h exp=%h", obs, exp_v); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL rst_async obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b1;
        step();
        reset = 1'b1;
        step();
        repeat (EXTRA) step();
        exp_v = {1'b0, 10'h000, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL rst_high_line_edge obs=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        exp_v = {1'b1, 10'h3F0, 2'b01, 2'b00};
        n_checks++;
        if (obs !== exp_v) $display("FAIL rst_mask_restored obs=%h exp=%h", obs, exp_v); else n_pass++;
        intr1 = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        iret = 1'b1;
        step();
        iret = 1'b0;
        step();
        exp_v = '0;
        n_checks++;
        if (obs !== exp_v) $display("FAIL rst_final obs=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_stretched_ack();
        test_edge_in_service();
        test_reset_in_req();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
